tl_link_monitor: RTL and testbench

- Synthesizable TileLink A/D-channel protocol monitor, parametrised in address, data and source-ID width.
- Sits beside a core's master port inside formal wrappers and simulation benches.
- Checks valid/ready stability rules and per-source request/response pairing, and flags response timeouts.
- Reports a sticky first-error code plus transaction counters, usable as an assert target or a cover source.

---
 rtl/tl_mon_pkg.sv | 35 +++
 rtl/tl_chan_stable.sv | 39 +++
 rtl/tl_link_monitor.sv | 158 +++++++++++++++
 tb/tb_tl_link_monitor.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_mon_pkg.sv
// Shared definitions for the TileLink A/D link monitor.
//   err_code_e  : violation codes reported on err_code (0 = no violation)
//   encode_err  : picks the lowest-numbered violation active this cycle
//   timer_width : width of a per-source response timer for a given timeout
package tl_mon_pkg;

    typedef enum logic [3:0] {
        NONE        = 4'd0,
        A_DROP      = 4'd1,
        A_UNSTABLE  = 4'd2,
        D_DROP      = 4'd3,
        D_UNSTABLE  = 4'd4,
        DUP_SOURCE  = 4'd5,
        ORPHAN_RESP = 4'd6,
        TIMEOUT     = 4'd7
    } err_code_e;

    // viol[k] is set when the rule with code k is broken this cycle.
    function automatic err_code_e encode_err(input logic [7:1] viol);
        if      (viol[1]) return A_DROP;
        else if (viol[2]) return A_UNSTABLE;
        else if (viol[3]) return D_DROP;
        else if (viol[4]) return D_UNSTABLE;
        else if (viol[5]) return DUP_SOURCE;
        else if (viol[6]) return ORPHAN_RESP;
        else if (viol[7]) return TIMEOUT;
        else              return NONE;
    endfunction

    // A timeout of 0 disables the timers; keep a legal 1-bit width then.
    function automatic int timer_width(input int timeout);
        return (timeout > 0) ? $clog2(timeout + 1) : 1;
    endfunction

endpackage

// File: rtl/tl_chan_stable.sv
// Valid/ready stability checker for one channel.
//   clock, resetn : clock and asynchronous active-low reset
//   valid, ready  : channel handshake (observed only)
//   payload       : all payload fields of the channel, concatenated
//   drop_err      : valid was stalled last cycle and has now dropped
//   unstable_err  : valid was stalled last cycle and the payload changed
module tl_chan_stable #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         valid,
    input  logic         ready,
    input  logic [W-1:0] payload,
    output logic         drop_err,
    output logic         unstable_err
);

    logic         stall_q;
    logic [W-1:0] snap_q;

    // NOTE: the snapshot is reset too, so the checker has no history on the
    // first cycle after reset and can never compare against stale data.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of process ordering.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            stall_q <= valid & ~ready;
            snap_q  <= payload;
        end
    end

    assign drop_err     = stall_q & ~valid;
    assign unstable_err = stall_q & (payload != snap_q);

endmodule

// File: rtl/tl_link_monitor.sv
// TileLink A/D channel protocol monitor.
//   clock, resetn    : clock and asynchronous active-low reset
//   a_* / d_*        : observed A and D channel signals (inputs only)
//   err              : sticky, set the cycle after the first violation
//   err_code         : code of the first violation (see tl_mon_pkg)
//   inflight         : per-source outstanding request bitmap
//   a_count, d_count : saturating counts of A and D fires
module tl_link_monitor #(
    parameter  int ADDR_W   = 32,
    parameter  int DATA_W   = 32,
    parameter  int SOURCE_W = 2,
    parameter  int SIZE_W   = 4,
    parameter  int TIMEOUT  = 255,
    parameter  int CNT_W    = 16,
    localparam int NSRC     = 2 ** SOURCE_W
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic [DATA_W/8-1:0] a_mask,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SIZE_W-1:0]   d_size,
    input  logic [SOURCE_W-1:0] d_source,
    input  logic [DATA_W-1:0]   d_data,
    input  logic                d_error,
    output logic                err,
    output logic [3:0]          err_code,
    output logic [NSRC-1:0]     inflight,
    output logic [CNT_W-1:0]    a_count,
    output logic [CNT_W-1:0]    d_count
);

    // The parameter TIMEOUT shares its name with an enum literal, so only
    // the needed package items are imported.
    import tl_mon_pkg::err_code_e;
    import tl_mon_pkg::NONE;
    import tl_mon_pkg::encode_err;
    import tl_mon_pkg::timer_width;

    localparam int TW   = timer_width(TIMEOUT);
    localparam int AP_W = 3 + SIZE_W + SOURCE_W + ADDR_W + DATA_W / 8 + DATA_W;
    localparam int DP_W = 3 + SIZE_W + SOURCE_W + DATA_W + 1;

    logic a_fire, d_fire;
    assign a_fire = a_valid & a_ready;
    assign d_fire = d_valid & d_ready;

    // ---------------- channel stability ----------------
    logic a_drop, a_unstable, d_drop, d_unstable;

    tl_chan_stable #(.W(AP_W)) u_a_stable (
        .clock        (clock),
        .resetn       (resetn),
        .valid        (a_valid),
        .ready        (a_ready),
        .payload      ({a_opcode, a_size, a_source, a_address, a_mask, a_data}),
        .drop_err     (a_drop),
        .unstable_err (a_unstable)
    );

    tl_chan_stable #(.W(DP_W)) u_d_stable (
        .clock        (clock),
        .resetn       (resetn),
        .valid        (d_valid),
        .ready        (d_ready),
        .payload      ({d_opcode, d_size, d_source, d_data, d_error}),
        .drop_err     (d_drop),
        .unstable_err (d_unstable)
    );

    // ---------------- per-source tracking ----------------
    logic [NSRC-1:0] inflight_q, inflight_d, launch, retire, timeout_hit;

    for (genvar s = 0; s < NSRC; s++) begin : g_src
        assign launch[s] = a_fire && (a_source == SOURCE_W'(s));
        assign retire[s] = d_fire && (d_source == SOURCE_W'(s));

        if (TIMEOUT > 0) begin : g_timer
            logic [TW-1:0] timer_q;

            // A launch (including a same-cycle retire + relaunch) restarts
            // the count; the timer parks at TIMEOUT once it gets there.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    timer_q <= '0;
                end else if (launch[s]) begin
                    timer_q <= '0;
                end else if (inflight_q[s] && timer_q != TW'(TIMEOUT)) begin
                    timer_q <= timer_q + TW'(1);
                end
            end

            assign timeout_hit[s] = inflight_q[s] && (timer_q == TW'(TIMEOUT));
        end else begin : g_no_timer
            assign timeout_hit[s] = 1'b0;
        end
    end

    // Retire first, then launch: a same-source A+D fire leaves the bit set.
    // An orphan retire clears a bit that is already clear, so it is a no-op.
    assign inflight_d = (inflight_q & ~retire) | launch;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) inflight_q <= '0;
        else         inflight_q <= inflight_d;
    end

    assign inflight = inflight_q;

    // ---------------- violation reporting ----------------
    logic       dup_source, orphan_resp;
    logic [7:1] viol;
    err_code_e  cycle_code, code_q;
    logic       err_q;

    // A duplicate launch is forgiven when the same cycle retires that source.
    assign dup_source  = a_fire && inflight_q[a_source] &&
                         !(d_fire && d_source == a_source);
    assign orphan_resp = d_fire && !inflight_q[d_source];

    assign viol = {(|timeout_hit), orphan_resp, dup_source,
                   d_unstable, d_drop, a_unstable, a_drop};
    assign cycle_code = encode_err(viol);

    // Only the first violation is latched; later ones are ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            err_q  <= 1'b0;
            code_q <= NONE;
        end else if (!err_q && cycle_code != NONE) begin
            err_q  <= 1'b1;
            code_q <= cycle_code;
        end
    end

    assign err      = err_q;
    assign err_code = code_q;

    // ---------------- saturating fire counters ----------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            a_count <= '0;
            d_count <= '0;
        end else begin
            if (a_fire && a_count != '1) a_count <= a_count + CNT_W'(1);
            if (d_fire && d_count != '1) d_count <= d_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tl_link_monitor.sv
// Self-checking bench for tl_link_monitor.
// A reference model steps once per clock edge from the link rules
// (launch times, first error, saturating counts) and pushes the expected
// outputs into a queue; a monitor on the falling edge pops and compares.
module tb_tl_link_monitor;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int SOURCE_W = 2;
    localparam int SIZE_W   = 4;
    localparam int TO       = 8;
    localparam int CNT_W    = 16;
    localparam int NSRC     = 4;
    localparam int CNT_MAX  = 2 ** CNT_W - 1;

    logic                clock = 1'b0;
    logic                resetn = 1'b0;
    logic                a_valid = 1'b0, a_ready = 1'b0;
    logic [2:0]          a_opcode = '0;
    logic [SIZE_W-1:0]   a_size = '0;
    logic [SOURCE_W-1:0] a_source = '0;
    logic [ADDR_W-1:0]   a_address = '0;
    logic [DATA_W/8-1:0] a_mask = '0;
    logic [DATA_W-1:0]   a_data = '0;
    logic                d_valid = 1'b0, d_ready = 1'b0;
    logic [2:0]          d_opcode = '0;
    logic [SIZE_W-1:0]   d_size = '0;
    logic [SOURCE_W-1:0] d_source = '0;
    logic [DATA_W-1:0]   d_data = '0;
    logic                d_error = 1'b0;
    logic                err;
    logic [3:0]          err_code;
    logic [NSRC-1:0]     inflight;
    logic [CNT_W-1:0]    a_count, d_count;

    tl_link_monitor #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SOURCE_W(SOURCE_W),
        .SIZE_W(SIZE_W), .TIMEOUT(TO), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .resetn(resetn),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
        .a_size(a_size), .a_source(a_source), .a_address(a_address),
        .a_mask(a_mask), .a_data(a_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_size(d_size), .d_source(d_source), .d_data(d_data),
        .d_error(d_error),
        .err(err), .err_code(err_code), .inflight(inflight),
        .a_count(a_count), .d_count(d_count)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [ADDR_W-1:0]   address;
        logic [DATA_W/8-1:0] mask;
        logic [DATA_W-1:0]   data;
    } a_pl_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic [DATA_W-1:0]   data;
        logic                error;
    } d_pl_t;

    typedef struct {
        logic             err;
        logic [3:0]       code;
        logic [NSRC-1:0]  inflight;
        logic [CNT_W-1:0] a_cnt;
        logic [CNT_W-1:0] d_cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // ---------------- reference model ----------------
    bit     m_inflight[NSRC];
    longint m_launch[NSRC];
    longint m_edge;
    int     m_code, m_acnt, m_dcnt;
    bit     m_a_stalled, m_d_stalled;
    a_pl_t  m_a_prev;
    d_pl_t  m_d_prev;

    function automatic void model_reset();
        for (int s = 0; s < NSRC; s++) begin
            m_inflight[s] = 1'b0;
            m_launch[s]   = 0;
        end
        m_code      = 0;
        m_acnt      = 0;
        m_dcnt      = 0;
        m_a_stalled = 1'b0;
        m_d_stalled = 1'b0;
        m_a_prev    = '0;
        m_d_prev    = '0;
    endfunction

    // Applies the link rules to the inputs present at this clock edge.
    function automatic void model_step();
        bit    hit[1:7];
        int    code;
        bit    a_f, d_f;
        a_pl_t a_now;
        d_pl_t d_now;
        m_edge++;
        a_f   = a_valid && a_ready;
        d_f   = d_valid && d_ready;
        a_now = '{a_opcode, a_size, a_source, a_address, a_mask, a_data};
        d_now = '{d_opcode, d_size, d_source, d_data, d_error};
        hit[1] = m_a_stalled && !a_valid;
        hit[2] = m_a_stalled && (a_now != m_a_prev);
        hit[3] = m_d_stalled && !d_valid;
        hit[4] = m_d_stalled && (d_now != m_d_prev);
        hit[5] = a_f && m_inflight[a_source] && !(d_f && d_source == a_source);
        hit[6] = d_f && !m_inflight[d_source];
        hit[7] = 1'b0;
        // A request launched at edge L may still be outstanding at edge L+TO;
        // still outstanding after that is a timeout.
        for (int s = 0; s < NSRC; s++)
            if (m_inflight[s] && (m_edge - m_launch[s] - 1) >= TO) hit[7] = 1'b1;
        code = 0;
        for (int k = 7; k >= 1; k--) if (hit[k]) code = k;
        if (m_code == 0) m_code = code;
        if (d_f) m_inflight[d_source] = 1'b0;
        if (a_f) begin
            m_inflight[a_source] = 1'b1;
            m_launch[a_source]   = m_edge;
        end
        if (a_f && m_acnt < CNT_MAX) m_acnt++;
        if (d_f && m_dcnt < CNT_MAX) m_dcnt++;
        m_a_stalled = a_valid && !a_ready;
        m_d_stalled = d_valid && !d_ready;
        m_a_prev    = a_now;
        m_d_prev    = d_now;
    endfunction

    function automatic exp_t model_view();
        exp_t e;
        e.err  = (m_code != 0);
        e.code = 4'(m_code);
        for (int s = 0; s < NSRC; s++) e.inflight[s] = m_inflight[s];
        e.a_cnt = CNT_W'(m_acnt);
        e.d_cnt = CNT_W'(m_dcnt);
        return e;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err",      64'(err),      64'(e.err));
            check("err_code", 64'(err_code), 64'(e.code));
            check("inflight", 64'(inflight), 64'(e.inflight));
            check("a_count",  64'(a_count),  64'(e.a_cnt));
            check("d_count",  64'(d_count),  64'(e.d_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    // One clock edge: step the model with the held inputs, optionally queue
    // the expected outputs, then return 1 time unit after the edge.
    task automatic tick(input bit chk);
        @(posedge clock);
        if (!resetn) model_reset();
        else         model_step();
        if (chk) exp_q.push_back(model_view());
        #1;
    endtask

    task automatic set_a(input bit v, input bit r, input int src, input logic [ADDR_W-1:0] addr);
        a_valid   = v;
        a_ready   = r;
        a_opcode  = 3'd4;
        a_size    = SIZE_W'(2);
        a_source  = SOURCE_W'(src);
        a_address = addr;
        a_mask    = '1;
        a_data    = DATA_W'(32'hA5A5_0000 | addr);
    endtask

    task automatic set_d(input bit v, input bit r, input int src);
        d_valid  = v;
        d_ready  = r;
        d_opcode = 3'd0;
        d_size   = SIZE_W'(2);
        d_source = SOURCE_W'(src);
        d_data   = '0;
        d_error  = 1'b0;
    endtask

    task automatic idle();
        set_a(0, 0, 0, '0);
        set_d(0, 0, 0);
    endtask

    // Asserts reset between edges (inputs untouched), checks that the
    // outputs clear without a clock edge, holds it for n edges, then
    // releases it just after an edge.
    task automatic do_reset(input int n);
        @(negedge clock);
        #1;
        resetn = 1'b0;
        model_reset();
        #1;
        check("async_rst_err",      64'(err),      64'(0));
        check("async_rst_err_code", 64'(err_code), 64'(0));
        check("async_rst_inflight", 64'(inflight), 64'(0));
        check("async_rst_a_count",  64'(a_count),  64'(0));
        check("async_rst_d_count",  64'(d_count),  64'(0));
        repeat (n) tick(1);
        resetn = 1'b1;
    endtask

    function automatic int pick_d_source();
        int s0;
        s0 = int'($urandom_range(0, NSRC - 1));
        if ($urandom_range(0, 4) != 0)
            for (int k = 0; k < NSRC; k++)
                if (m_inflight[(s0 + k) % NSRC]) return (s0 + k) % NSRC;
        return s0;
    endfunction

    task automatic random_episode(input int len);
        idle();
        do_reset(2);
        for (int c = 0; c < len; c++) begin
            if (!(a_valid && !a_ready && $urandom_range(0, 9) != 0)) begin
                a_valid   = 1'($urandom_range(0, 1));
                a_opcode  = ($urandom_range(0, 1) != 0) ? 3'd4 : 3'd0;
                a_size    = SIZE_W'(2);
                a_source  = SOURCE_W'($urandom_range(0, NSRC - 1));
                a_address = ($urandom_range(0, 1) != 0) ? 32'h100 : 32'h104;
                a_mask    = DATA_W'(4'hF) >> $urandom_range(0, 1);
                a_data    = DATA_W'($urandom_range(0, 3));
            end
            a_ready = 1'($urandom_range(0, 1));
            if (!(d_valid && !d_ready && $urandom_range(0, 9) != 0)) begin
                d_valid  = ($urandom_range(0, 9) < 4);
                d_opcode = 3'd1;
                d_size   = SIZE_W'(2);
                d_source = SOURCE_W'(pick_d_source());
                d_data   = DATA_W'($urandom_range(0, 3));
                d_error  = ($urandom_range(0, 7) == 0);
            end
            d_ready = 1'($urandom_range(0, 1));
            tick(1);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        m_edge = 0;
        model_reset();

        // Reset, then 20 idle cycles.
        idle();
        do_reset(3);
        repeat (20) tick(1);
        check("idle_err",      64'(err),      64'(0));
        check("idle_err_code", 64'(err_code), 64'(0));
        check("idle_inflight", 64'(inflight), 64'(0));
        check("idle_a_count",  64'(a_count),  64'(0));

        // Stalled A on source 1 with stable payload, then fire; D 5 cycles later.
        set_a(1, 0, 1, 32'h0001_0000);
        repeat (3) tick(1);
        a_ready = 1'b1;
        tick(1);
        check("pair_inflight_after_a", 64'(inflight), 64'h2);
        idle();
        repeat (4) tick(1);
        set_d(1, 1, 1);
        tick(1);
        idle();
        tick(1);
        check("pair_inflight_after_d", 64'(inflight), 64'h0);
        check("pair_a_count",          64'(a_count),  64'd1);
        check("pair_d_count",          64'(d_count),  64'd1);
        check("pair_err",              64'(err),      64'd0);

        // Address changes while stalled -> code 2; a later D drop keeps it.
        set_a(1, 0, 0, 32'h100);
        tick(1);
        a_address = 32'h104;
        tick(1);
        check("unstable_code", 64'(err_code), 64'd2);
        idle();
        set_d(1, 0, 0);
        tick(1);
        d_valid = 1'b0;
        repeat (2) tick(1);
        check("unstable_code_sticky", 64'(err_code), 64'd2);

        // Orphan response on source 3.
        idle();
        do_reset(2);
        set_d(1, 1, 3);
        tick(1);
        idle();
        tick(1);
        check("orphan_code",     64'(err_code), 64'd6);
        check("orphan_inflight", 64'(inflight), 64'd0);

        // Two launches on source 0 without a response.
        do_reset(2);
        set_a(1, 1, 0, 32'h200);
        repeat (2) tick(1);
        idle();
        tick(1);
        check("dup_code",     64'(err_code), 64'd5);
        check("dup_inflight", 64'(inflight), 64'h1);

        // Timeout on source 2: clean after 8 edges, code 7 after 9.
        do_reset(2);
        set_a(1, 1, 2, 32'h300);
        tick(1);
        idle();
        repeat (8) tick(1);
        check("timeout_not_yet", 64'(err), 64'd0);
        tick(1);
        check("timeout_code", 64'(err_code), 64'd7);

        // Same-cycle A+D on source 2 restarts the timer.
        do_reset(2);
        set_a(1, 1, 2, 32'h300);
        tick(1);
        idle();
        repeat (4) tick(1);
        set_a(1, 1, 2, 32'h304);
        set_d(1, 1, 2);
        tick(1);
        check("relaunch_inflight", 64'(inflight), 64'h4);
        idle();
        repeat (6) tick(1);
        set_d(1, 1, 2);
        tick(1);
        idle();
        tick(1);
        check("relaunch_err",      64'(err),      64'd0);
        check("relaunch_inflight_clear", 64'(inflight), 64'h0);

        // Randomised episodes against the model.
        for (int ep = 0; ep < 40; ep++) random_episode(60);

        // Reset mid-stall with tracking live; no drop flagged after release.
        idle();
        do_reset(2);
        set_a(1, 1, 3, 32'h400);
        tick(1);
        set_a(1, 0, 1, 32'h500);
        repeat (2) tick(1);
        do_reset(2);
        idle();
        repeat (2) tick(1);
        check("post_reset_no_drop", 64'(err_code), 64'd0);

        // Counter saturation: 70000 back-to-back fires.
        do_reset(2);
        set_a(1, 1, 0, 32'h600);
        set_d(1, 1, 0);
        for (int i = 0; i < 70000; i++) tick((i % 4096) == 0 || i >= 69995);
        idle();
        tick(1);
        check("sat_a_count", 64'(a_count), 64'hFFFF);
        check("sat_d_count", 64'(d_count), 64'hFFFF);

        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
